alu_acc: RTL
============

// Module: alu_acc
// PURPOSE
//  Datapath stage directly downstream of the B-bus source mux; consumes B_bus each operation.
//  Applies a 4-bit ALU op to AC (A operand) and B_bus (B operand), writes the result back to AC and updates Z/C flags.
//  All ops take one cycle except MUL, a GPRWIDTH-cycle shift-add multiply.
//  The control unit issues ops with a start pulse and waits on busy/done.
// PARAMETERS
//  GPRWIDTH     24  datapath/AC width, matches the B-bus width
//  CONTROLBITS   4  alu_op width
// PORTS
//  clk        in   1           single clock; all state updates on rising edge
//  rst        in   1           synchronous, active-high reset
//  B_bus      in   GPRWIDTH    B operand from the B-bus mux
//  alu_op     in   CONTROLBITS operation code, sampled with alu_start
//  alu_start  in   1           issue op; accepted only when busy==0
//  AC         out  GPRWIDTH    accumulator (registered)
//  Z          out  1           AC==0 after the last AC write
//  C          out  1           carry/borrow of the last ADD/SUB/INC
//  busy       out  1           MUL in progress; new starts ignored
//  done       out  1           one-cycle pulse: op complete, AC/Z/C valid
// BEHAVIOUR
//  Reset (rst=1 at edge): AC=0, Z=1, C=0, busy=0, done=0, state=IDLE; aborts any MUL, discards partial product.
//  Op codes:
//   0 NOP (done pulses, AC/flags unchanged)
//   1 PASS AC<=B
//   2 ADD AC<=AC+B, C=carry out
//   3 SUB AC<=AC-B, C=borrow (AC<B unsigned)
//   4 AND
//   5 OR
//   6 XOR
//   7 INC AC<=AC+1, C=carry out
//   8 CLR AC<=0
//   9 SHL AC<=AC<<1, 0 in
//   10 SHR logical, 0 in
//   11 MUL AC<=(AC*B)[GPRWIDTH-1:0], unsigned, truncated
//   12-15 treated as NOP
//  C changes only on ops 2, 3, 7. Z is recomputed on every AC write; NOP leaves Z unchanged.
//  FSM states: IDLE, MUL.
//  IDLE, single-cycle op:
//   - the edge sampling alu_start writes AC/Z/C and sets done=1 for the next cycle only.
//   - Latency: 1 cycle.
//  IDLE + start + MUL:
//   - capture mcand=AC, mplier=B, prod=0, cnt=0; state->MUL, busy=1 from the next cycle.
//   - AC is not modified until completion.
//  MUL, each edge:
//   - if mplier[0], prod += mcand
//   - mcand <<= 1, mplier >>= 1, cnt++
//   - on the edge where cnt==GPRWIDTH-1: AC<=final prod, Z updated, C unchanged, done=1, busy=0, state->IDLE.
//   - busy is high for exactly GPRWIDTH cycles; done is high in the cycle after the start edge + GPRWIDTH edges.
//  alu_start while busy=1: ignored, not queued. B_bus is don't-care during MUL; operands were captured at start.
//  alu_start in the cycle done=1 (IDLE): accepted normally, so back-to-back single-cycle ops pulse done every cycle.
//  All arithmetic is modulo 2^GPRWIDTH; no signed interpretation, no overflow flag.
// STRUCTURE
//  alu_pkg holds: op-code localparams (ALU_NOP..ALU_MUL), GPRWIDTH/CONTROLBITS defaults, and state encodings IDLE/MUL.
//  One sub-module: seq_mul, the shift-add multiplier.
//   - holds mcand/mplier/prod/cnt
//   - ports: clk, rst, start, a, b, busy, done, p
//  alu_acc holds the combinational ALU, the AC/Z/C registers, and the mux of the seq_mul result into AC.
// TESTING
//  1. Reset: after rst -> AC=0, Z=1, C=0, busy=0, done=0. Then rst with MUL mid-way (cycle 10) -> same values, no done pulse.
//  2. PASS B=24'h000005, then ADD B=24'hFFFFFB -> AC=0, Z=1, C=1; done pulses once per op, 1 cycle after each start.
//  3. SUB: AC=3, B=5 -> AC=24'hFFFFFE, C=1, Z=0. INC at AC=24'hFFFFFF -> AC=0, C=1, Z=1.
//  4. MUL: AC=24'h000123, B=24'h000045 -> busy high 24 cycles, then AC=24'h004E6F, done once.
//     Overflow case: AC=24'h100000, B=24'h000010 -> AC=0, Z=1.
//  5. Start with ADD while busy (mid-MUL) -> ignored; MUL result and AC unaffected, single done.
//  6. Back-to-back: AND, OR, XOR, SHL, SHR, CLR, op 13 on consecutive cycles.
//     -> done high on 7 consecutive cycles; each AC matches the reference model; op 13 leaves AC/Z/C unchanged.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the accumulator ALU: default widths, op codes, and multiplier FSM states.
package alu_pkg;

  localparam int ALU_GPRWIDTH    = 24;
  localparam int ALU_CONTROLBITS = 4;

  localparam logic [3:0] ALU_NOP  = 4'd0;
  localparam logic [3:0] ALU_PASS = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_OR   = 4'd5;
  localparam logic [3:0] ALU_XOR  = 4'd6;
  localparam logic [3:0] ALU_INC  = 4'd7;
  localparam logic [3:0] ALU_CLR  = 4'd8;
  localparam logic [3:0] ALU_SHL  = 4'd9;
  localparam logic [3:0] ALU_SHR  = 4'd10;
  localparam logic [3:0] ALU_MUL  = 4'd11;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } mul_state_e;

endpackage

// File: rtl/alu_acc_if.sv
// Control-unit <-> accumulator ALU bundle: operand, op issue, and AC/flag/status return.
interface alu_acc_if #(
  parameter int GPRWIDTH    = 24,
  parameter int CONTROLBITS = 4
);
  logic [GPRWIDTH-1:0]    B_bus;
  logic [CONTROLBITS-1:0] alu_op;
  logic                   alu_start;
  logic [GPRWIDTH-1:0]    AC;
  logic                   Z;
  logic                   C;
  logic                   busy;
  logic                   done;

  modport master (
    output B_bus, alu_op, alu_start,
    input  AC, Z, C, busy, done
  );

  modport slave (
    input  B_bus, alu_op, alu_start,
    output AC, Z, C, busy, done
  );
endinterface

// File: rtl/seq_mul.sv
// Shift-add unsigned multiplier, one multiplier bit per cycle, result truncated to GPRWIDTH.
module seq_mul
  import alu_pkg::*;
#(
  parameter int GPRWIDTH = ALU_GPRWIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [GPRWIDTH-1:0] a,
  input  logic [GPRWIDTH-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [GPRWIDTH-1:0] p
);
  localparam int CNT_W = $clog2(GPRWIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GPRWIDTH - 1);

  mul_state_e          state_q, state_d;
  logic [GPRWIDTH-1:0] mcand, mplier, prod;
  logic [CNT_W-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = MUL;
      MUL: begin
        busy = 1'b1;
        if (cnt == LAST) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p is the product after this cycle's partial add; the top latches it on done.
  assign p = mplier[0] ? prod + mcand : prod;

  always_ff @(posedge clk) begin
    if (rst)                             cnt <= '0;
    else if (state_q == IDLE && start)   cnt <= '0;
    else if (state_q == MUL)             cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && start) begin
      mcand  <= a;
      mplier <= b;
      prod   <= '0;
    end else if (state_q == MUL) begin
      prod   <= p;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end
endmodule

// File: rtl/alu_acc.sv
// Accumulator ALU: single-cycle ops on AC and B_bus, plus a multi-cycle multiply via seq_mul.
module alu_acc
  import alu_pkg::*;
#(
  parameter int GPRWIDTH    = ALU_GPRWIDTH,
  parameter int CONTROLBITS = ALU_CONTROLBITS
) (
  input  logic      clk,
  input  logic      rst,
  alu_acc_if.slave  bus
);
  logic [GPRWIDTH-1:0] ac_q, alu_res, mul_p;
  logic [GPRWIDTH:0]   sum_ext;
  logic                z_q, c_q, done_q;
  logic                alu_c, wr_ac;
  logic                accept, is_mul, mul_busy, mul_done;

  assign accept = bus.alu_start && !mul_busy;
  assign is_mul = (bus.alu_op == CONTROLBITS'(ALU_MUL));

  always_comb begin
    alu_res = ac_q;
    alu_c   = c_q;
    wr_ac   = 1'b1;
    sum_ext = '0;
    case (bus.alu_op)
      CONTROLBITS'(ALU_PASS): alu_res = bus.B_bus;
      CONTROLBITS'(ALU_ADD): begin
        sum_ext = {1'b0, ac_q} + {1'b0, bus.B_bus};
        alu_res = sum_ext[GPRWIDTH-1:0];
        alu_c   = sum_ext[GPRWIDTH];
      end
      CONTROLBITS'(ALU_SUB): begin
        // Bit GPRWIDTH of the extended difference is the unsigned borrow.
        sum_ext = {1'b0, ac_q} - {1'b0, bus.B_bus};
        alu_res = sum_ext[GPRWIDTH-1:0];
        alu_c   = sum_ext[GPRWIDTH];
      end
      CONTROLBITS'(ALU_AND): alu_res = ac_q & bus.B_bus;
      CONTROLBITS'(ALU_OR):  alu_res = ac_q | bus.B_bus;
      CONTROLBITS'(ALU_XOR): alu_res = ac_q ^ bus.B_bus;
      CONTROLBITS'(ALU_INC): begin
        sum_ext = {1'b0, ac_q} + (GPRWIDTH+1)'(1);
        alu_res = sum_ext[GPRWIDTH-1:0];
        alu_c   = sum_ext[GPRWIDTH];
      end
      CONTROLBITS'(ALU_CLR): alu_res = '0;
      CONTROLBITS'(ALU_SHL): alu_res = {ac_q[GPRWIDTH-2:0], 1'b0};
      CONTROLBITS'(ALU_SHR): alu_res = {1'b0, ac_q[GPRWIDTH-1:1]};
      default:               wr_ac   = 1'b0;
    endcase
  end

  seq_mul #(.GPRWIDTH(GPRWIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (accept && is_mul),
    .a     (ac_q),
    .b     (bus.B_bus),
    .busy  (mul_busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // mul_done only occurs while busy, so it never collides with an accepted op.
  always_ff @(posedge clk) begin
    if (rst) begin
      ac_q   <= '0;
      z_q    <= 1'b1;
      c_q    <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (mul_done) begin
        ac_q   <= mul_p;
        z_q    <= (mul_p == '0);
        done_q <= 1'b1;
      end else if (accept && !is_mul) begin
        done_q <= 1'b1;
        c_q    <= alu_c;
        if (wr_ac) begin
          ac_q <= alu_res;
          z_q  <= (alu_res == '0);
        end
      end
    end
  end

  assign bus.AC   = ac_q;
  assign bus.Z    = z_q;
  assign bus.C    = c_q;
  assign bus.busy = mul_busy;
  assign bus.done = done_q;
endmodule
